// File: rtl/mmio_combiner_pkg.sv
// Shared encodings for the register-mapped channel combiner: operation modes,
// register addresses and the FIFO occupancy-count width.
package mmio_combiner_pkg;

  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_ADD = 2'd3
  } mode_e;

  localparam logic [2:0] WA_CTRL      = 3'd0;
  localparam logic [2:0] WA_CH0       = 3'd4;

  localparam logic [2:0] RA_NOT_FULL  = 3'd0;
  localparam logic [2:0] RA_OUT_STAT  = 3'd1;
  localparam logic [2:0] RA_OUT_COUNT = 3'd2;
  localparam logic [2:0] RA_OUT_POP   = 3'd3;
  localparam logic [2:0] RA_CTRL      = 3'd4;
  localparam logic [2:0] RA_OVF       = 3'd5;

  // One extra bit over the pointer width keeps full and empty distinct.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output. Push is ignored when full and
// pop is ignored when empty, both judged on the count at the start of the cycle.
module sync_fifo
  import mmio_combiner_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_combiner.sv
// Register-mapped combiner: NUM_CH input FIFOs are popped in lock-step, their
// heads reduced by the programmed operation, and the result queued for readback.
module mmio_combiner
  import mmio_combiner_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int NUM_CH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [2:0]        write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [2:0]        read_address,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_rdy,
  output logic              read_valid
);

  localparam int CW = cnt_w(DEPTH);

  mode_e              mode;
  logic [NUM_CH-1:0]  ovf;
  logic [NUM_CH-1:0]  new_ovf;
  logic [NUM_CH-1:0]  ch_push;
  logic [NUM_CH-1:0]  ch_full;
  logic [NUM_CH-1:0]  ch_empty;
  logic [DATA_W-1:0]  head [NUM_CH];
  logic [CW-1:0]      ch_count_unused [NUM_CH];

  logic               out_full;
  logic               out_empty;
  logic [CW-1:0]      out_count;
  logic [DATA_W-1:0]  out_dout;

  logic               wr_acc;
  logic               rd_acc;
  logic               out_pop;
  logic               fire;
  logic [DATA_W-1:0]  comb_result;
  logic [DATA_W-1:0]  rd_mux;

  function automatic logic [DATA_W-1:0] combine2(input mode_e m,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    case (m)
      MODE_AND: combine2 = a & b;
      MODE_XOR: combine2 = a ^ b;
      MODE_ADD: combine2 = a + b;
      default:  combine2 = a | b;
    endcase
  endfunction

  assign wr_acc   = write_en && write_rdy;
  assign read_rdy = RST_N && !((read_address == RA_OUT_POP) && out_empty);
  assign rd_acc   = read_en && read_rdy;
  assign out_pop  = rd_acc && (read_address == RA_OUT_POP);
  assign fire     = (&(~ch_empty)) && !out_full;
  assign new_ovf  = ch_push & ch_full;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_push[i] = wr_acc && (write_address == WA_CH0 + 3'(i));

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .push  (ch_push[i]),
      .pop   (fire),
      .din   (write_data),
      .dout  (head[i]),
      .full  (ch_full[i]),
      .empty (ch_empty[i]),
      .count (ch_count_unused[i])
    );
  end

  // Left-fold of all channel heads using the mode in effect this cycle.
  always_comb begin
    comb_result = head[0];
    for (int i = 1; i < NUM_CH; i++) begin
      comb_result = combine2(mode, comb_result, head[i]);
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (fire),
    .pop   (out_pop),
    .din   (comb_result),
    .dout  (out_dout),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  always_comb begin
    rd_mux = '0;
    case (read_address)
      RA_NOT_FULL:  rd_mux[NUM_CH-1:0] = ~ch_full;
      RA_OUT_STAT:  rd_mux[1:0]        = {out_full, ~out_empty};
      RA_OUT_COUNT: rd_mux[CW-1:0]     = out_count;
      RA_OUT_POP:   rd_mux             = out_dout;
      RA_CTRL:      rd_mux[1:0]        = mode;
      RA_OVF:       rd_mux[NUM_CH-1:0] = ovf;
      default:      rd_mux             = '0;
    endcase
  end

  // Register stage: read result, control and sticky overflow flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      write_rdy  <= 1'b0;
      mode       <= MODE_OR;
      ovf        <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      write_rdy  <= 1'b1;
      read_valid <= rd_acc;
      if (rd_acc) read_data <= rd_mux;
      if (wr_acc && (write_address == WA_CTRL)) mode <= mode_e'(write_data[1:0]);
      // Clear-on-read still keeps an overflow raised in the same cycle.
      if (rd_acc && (read_address == RA_OVF)) ovf <= new_ovf;
      else                                    ovf <= ovf | new_ovf;
    end
  end

endmodule

// File: tb/tb_mmio_combiner.sv
// Self-checking bench for mmio_combiner: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_mmio_combiner;

  localparam int DEPTH = 4;
  localparam int NCH   = 2;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] w_addr, r_addr, w4_addr, r4_addr;
  logic [7:0] w_data, w4_data;
  logic       w_en, r_en, w4_en, r4_en;
  logic       w_rdy, r_rdy, r_valid, w4_rdy, r4_rdy, r4_valid;
  logic [7:0] r_data, r4_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] chq [NCH][$];
  logic [7:0] outq[$];
  logic [1:0] m_mode;
  logic [NCH-1:0] m_ovf;
  logic [7:0] m_last;

  always #5 CLK = ~CLK;

  mmio_combiner #(.DATA_W(8), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .write_address(w_addr), .write_data(w_data), .write_en(w_en), .write_rdy(w_rdy),
    .read_address(r_addr), .read_en(r_en), .read_data(r_data),
    .read_rdy(r_rdy), .read_valid(r_valid)
  );

  mmio_combiner #(.DATA_W(8), .DEPTH(DEPTH), .NUM_CH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N),
    .write_address(w4_addr), .write_data(w4_data), .write_en(w4_en), .write_rdy(w4_rdy),
    .read_address(r4_addr), .read_en(r4_en), .read_data(r4_data),
    .read_rdy(r4_rdy), .read_valid(r4_valid)
  );

  // ---------------- drivers ----------------
  task automatic do_write(input bit sel, input logic [2:0] a, input logic [7:0] d);
    if (sel) begin w4_addr = a; w4_data = d; w4_en = 1'b1; end
    else     begin w_addr  = a; w_data  = d; w_en  = 1'b1; end
    @(posedge CLK); #1;
    w_en = 1'b0; w4_en = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic do_read(input bit sel, input logic [2:0] a,
                         output logic [7:0] d, output logic rdy, output logic vld);
    if (sel) begin r4_addr = a; r4_en = 1'b1; end
    else     begin r_addr  = a; r_en  = 1'b1; end
    #1;
    rdy = sel ? r4_rdy : r_rdy;
    @(posedge CLK); #1;
    r_en = 1'b0; r4_en = 1'b0;
    d   = sel ? r4_data : r_data;
    vld = sel ? r4_valid : r_valid;
    @(posedge CLK); #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] op2(input logic [1:0] md, input logic [7:0] a, input logic [7:0] b);
    case (md)
      2'd0: return a | b;
      2'd1: return a & b;
      2'd2: return a ^ b;
      default: return 8'((int'(a) + int'(b)) % 256);
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) chq[i].delete();
    outq.delete();
    m_mode = 2'd0; m_ovf = '0; m_last = 8'h00;
  endtask

  task automatic model_settle();
    logic [7:0] r;
    bit ok;
    while (1) begin
      ok = (outq.size() < DEPTH);
      for (int i = 0; i < NCH; i++) if (chq[i].size() == 0) ok = 0;
      if (!ok) break;
      r = chq[0].pop_front();
      for (int i = 1; i < NCH; i++) r = op2(m_mode, r, chq[i].pop_front());
      outq.push_back(r);
    end
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    int ch;
    if (a == 3'd0) m_mode = d[1:0];
    else if (a >= 3'd4) begin
      ch = int'(a) - 4;
      if (ch < NCH) begin
        if (chq[ch].size() >= DEPTH) m_ovf[ch] = 1'b1;
        else chq[ch].push_back(d);
      end
    end
    model_settle();
  endtask

  task automatic model_read(input logic [2:0] a, output logic [7:0] d, output logic rdy);
    rdy = 1'b1;
    case (a)
      3'd0: begin
        m_last = 8'h00;
        for (int i = 0; i < NCH; i++) m_last[i] = (chq[i].size() < DEPTH);
      end
      3'd1: m_last = {6'd0, outq.size() == DEPTH, outq.size() != 0};
      3'd2: m_last = 8'(outq.size());
      3'd3: begin
        if (outq.size() == 0) rdy = 1'b0;
        else begin m_last = outq.pop_front(); model_settle(); end
      end
      3'd4: m_last = {6'd0, m_mode};
      3'd5: begin m_last = 8'(m_ovf); m_ovf = '0; end
      default: m_last = 8'h00;
    endcase
    d = m_last;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset_or();
    logic [7:0] d; logic rdy, vld;
    RST_N = 1'b0; r_addr = 3'd1; r4_addr = 3'd1;
    repeat (2) @(posedge CLK);
    #1;
    n_vec++; if (r_data !== 8'h00 || r_valid !== 1'b0) begin n_err++; $display("FAIL reset_read: data=%h valid=%b want 00/0", r_data, r_valid); end
    n_vec++; if (w_rdy !== 1'b0) begin n_err++; $display("FAIL reset_write_rdy: got %b want 0", w_rdy); end
    n_vec++; if (r_rdy !== 1'b0) begin n_err++; $display("FAIL reset_read_rdy: got %b want 0", r_rdy); end
    RST_N = 1'b1; #1;
    n_vec++; if (w_rdy !== 1'b0) begin n_err++; $display("FAIL first_cycle_write_rdy: got %b want 0", w_rdy); end
    @(posedge CLK); #1;
    n_vec++; if (w_rdy !== 1'b1) begin n_err++; $display("FAIL write_rdy_up: got %b want 1", w_rdy); end
    do_read(0, 3'd1, d, rdy, vld);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL out_status_reset: got %h want 00", d); end
    do_read(0, 3'd0, d, rdy, vld);
    n_vec++; if (d !== 8'h03) begin n_err++; $display("FAIL not_full_reset: got %h want 03", d); end
    do_write(0, 3'd4, 8'h0F);
    do_write(0, 3'd5, 8'hF0);
    do_read(0, 3'd3, d, rdy, vld);
    n_vec++; if (d !== 8'hFF || vld !== 1'b1 || rdy !== 1'b1) begin n_err++; $display("FAIL or_result: data=%h valid=%b rdy=%b want ff/1/1", d, vld, rdy); end
    do_read(0, 3'd1, d, rdy, vld);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL out_status_drained: got %h want 00", d); end
  endtask

  task automatic test_modes();
    logic [7:0] d; logic rdy, vld;
    logic [7:0] want [3] = '{8'h42, 8'h99, 8'h1D};
    for (int m = 1; m <= 3; m++) begin
      do_write(0, 3'd0, 8'(m));
      do_write(0, 3'd4, 8'hC3);
      do_write(0, 3'd5, 8'h5A);
      do_read(0, 3'd3, d, rdy, vld);
      n_vec++; if (d !== want[m-1] || vld !== 1'b1) begin n_err++; $display("FAIL mode_%0d: data=%h valid=%b want %h/1", m, d, vld, want[m-1]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic rdy, vld;
    do_write(0, 3'd0, 8'h00);
    for (int i = 1; i <= 5; i++) do_write(0, 3'd4, 8'(i * 17));
    do_read(0, 3'd0, d, rdy, vld);
    n_vec++; if (d !== 8'h02) begin n_err++; $display("FAIL ovf_not_full: got %h want 02", d); end
    do_read(0, 3'd5, d, rdy, vld);
    n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL ovf_sticky: got %h want 01", d); end
    do_read(0, 3'd5, d, rdy, vld);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL ovf_cleared: got %h want 00", d); end
    for (int i = 0; i < 4; i++) do_write(0, 3'd5, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      do_read(0, 3'd3, d, rdy, vld);
      n_vec++; if (d !== 8'(i * 17)) begin n_err++; $display("FAIL ovf_data_%0d: got %h want %h", i, d, 8'(i * 17)); end
    end
    do_read(0, 3'd1, d, rdy, vld);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL ovf_word_dropped: got %h want 00", d); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d; logic rdy, vld;
    for (int i = 1; i <= 6; i++) begin
      do_write(0, 3'd4, 8'(i));
      do_write(0, 3'd5, 8'h00);
    end
    do_read(0, 3'd2, d, rdy, vld);
    n_vec++; if (d !== 8'd4) begin n_err++; $display("FAIL bp_count: got %h want 04", d); end
    do_read(0, 3'd1, d, rdy, vld);
    n_vec++; if (d !== 8'h03) begin n_err++; $display("FAIL bp_status: got %h want 03", d); end
    do_read(0, 3'd3, d, rdy, vld);
    n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL bp_first: got %h want 01", d); end
    do_read(0, 3'd2, d, rdy, vld);
    n_vec++; if (d !== 8'd4) begin n_err++; $display("FAIL bp_refill: got %h want 04", d); end
    for (int i = 2; i <= 6; i++) begin
      do_read(0, 3'd3, d, rdy, vld);
      n_vec++; if (d !== 8'(i)) begin n_err++; $display("FAIL bp_drain_%0d: got %h want %h", i, d, 8'(i)); end
    end
  endtask

  task automatic test_empty_read();
    logic [7:0] d; logic rdy, vld;
    do_write(0, 3'd0, 8'h02);
    do_read(0, 3'd4, d, rdy, vld);
    n_vec++; if (d !== 8'h02) begin n_err++; $display("FAIL ctrl_readback: got %h want 02", d); end
    do_read(0, 3'd3, d, rdy, vld);
    n_vec++; if (rdy !== 1'b0 || vld !== 1'b0 || d !== 8'h02) begin n_err++; $display("FAIL empty_pop: rdy=%b valid=%b data=%h want 0/0/02", rdy, vld, d); end
    do_read(0, 3'd2, d, rdy, vld);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL empty_count: got %h want 00", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic rdy, vld;
    do_write(0, 3'd4, 8'hA1);
    do_write(0, 3'd4, 8'hA2);
    do_write(0, 3'd4, 8'hA3);
    do_write(0, 3'd5, 8'h0F);
    do_read(0, 3'd2, d, rdy, vld);
    n_vec++; if (d !== 8'd1) begin n_err++; $display("FAIL mid_pre_count: got %h want 01", d); end
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    do_read(0, 3'd2, d, rdy, vld);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL mid_count: got %h want 00", d); end
    do_read(0, 3'd0, d, rdy, vld);
    n_vec++; if (d !== 8'h03) begin n_err++; $display("FAIL mid_not_full: got %h want 03", d); end
    do_read(0, 3'd4, d, rdy, vld);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL mid_mode: got %h want 00", d); end
    do_write(0, 3'd5, 8'h55);
    do_read(0, 3'd1, d, rdy, vld);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL mid_inputs_discarded: got %h want 00", d); end
  endtask

  task automatic test_four_way();
    logic [7:0] d; logic rdy, vld;
    do_read(1, 3'd0, d, rdy, vld);
    n_vec++; if (d !== 8'h0F) begin n_err++; $display("FAIL four_not_full: got %h want 0f", d); end
    do_write(1, 3'd0, 8'h02);
    for (int i = 0; i < 4; i++) do_write(1, 3'(4 + i), 8'(1 << i));
    do_read(1, 3'd3, d, rdy, vld);
    n_vec++; if (d !== 8'h0F || vld !== 1'b1) begin n_err++; $display("FAIL four_xor: data=%h valid=%b want 0f/1", d, vld); end
  endtask

  task automatic test_random();
    logic [7:0] d, ed, wd; logic rdy, vld, erdy;
    logic [2:0] a;
    int op;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    model_clear();
    for (int k = 0; k < 300; k++) begin
      op = int'($urandom_range(0, 9));
      wd = 8'($urandom);
      if (op <= 3) begin
        a = 3'(4 + $urandom_range(0, 3));
        do_write(0, a, wd); model_write(a, wd);
      end else if (op == 4) begin
        do_write(0, 3'd0, wd); model_write(3'd0, wd);
      end else if (op == 5) begin
        a = 3'($urandom_range(1, 3));
        do_write(0, a, wd); model_write(a, wd);
      end else begin
        a = 3'($urandom_range(0, 7));
        do_read(0, a, d, rdy, vld);
        model_read(a, ed, erdy);
        n_vec++;
        if (rdy !== erdy || vld !== erdy || d !== ed) begin
          n_err++;
          $display("FAIL rand_read_%0d addr=%0d: data=%h rdy=%b valid=%b want %h/%b/%b", k, a, d, rdy, vld, ed, erdy, erdy);
        end
      end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    w_addr = '0; w_data = '0; w_en = 1'b0; r_addr = '0; r_en = 1'b0;
    w4_addr = '0; w4_data = '0; w4_en = 1'b0; r4_addr = '0; r4_en = 1'b0;
    @(posedge CLK); #1;
    test_reset_or();
    test_modes();
    test_overflow();
    test_backpressure();
    test_empty_read();
    test_reset_mid();
    test_four_way();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
